// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: word array with B/H/W access and optional wait states.
// Build macro DMEM_FAULT_CHECK_EN enables access fault detection; without it mem_fault is tied low.
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAddr,
    input  logic [2:0]  MemOp,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemDataIn,
    output logic [31:0] MemReadDataOut,
    output logic        mem_ready,
    output logic        mem_fault
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem_q [DEPTH];

    // Access under decode: live inputs in zero-wait mode, captured copies in wait mode.
    logic [31:0]   a_addr, a_data;
    logic [2:0]    a_op;
    logic          a_rd, a_wr;

    logic [31:0]   woff;
    logic [IW-1:0] idx;
    logic          in_range;
    logic [1:0]    lane;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wdata, rword, ldval;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          exec;

    always_comb begin
        woff     = (a_addr - BASE_ADDR) >> 2;
        lane     = a_addr[1:0];
        fault    = 1'b0;
`ifdef DMEM_FAULT_CHECK_EN
        idx      = woff[IW-1:0];
        in_range = (woff < 32'(DEPTH));
        if (a_rd && a_wr)                                    fault = 1'b1;
        if (a_op == 3'b011 || a_op[2:1] == 2'b11)            fault = 1'b1;
        if (a_wr && (a_op == 3'b100 || a_op == 3'b101))      fault = 1'b1;
        if (a_op[1:0] == 2'b01 && lane[0])                   fault = 1'b1;
        if (a_op == 3'b010 && lane != 2'b00)                 fault = 1'b1;
        if (!in_range)                                       fault = 1'b1;
        if (!(a_rd || a_wr))                                 fault = 1'b0;
`else
        idx      = IW'(woff % 32'(DEPTH));
        in_range = 1'b1;
        // Unchecked: halves force even lane, words (and reserved ops) force lane 0.
        if (a_op[1:0] == 2'b01)      lane[0] = 1'b0;
        else if (a_op[1:0] != 2'b00) lane    = 2'b00;
`endif
        rword = in_range ? mem_q[idx] : '0;
        bsel  = rword[{lane, 3'b000} +: 8];
        hsel  = lane[1] ? rword[31:16] : rword[15:0];

        case (a_op[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{a_data[7:0]}};
                ldval = a_op[2] ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{a_data[15:0]}};
                ldval = a_op[2] ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            end
            default: begin
                be    = 4'b1111;
                wdata = a_data;
                ldval = rword;
            end
        endcase
        if (fault) ldval = '0;
    end

    always_ff @(posedge clk) begin
        if (exec && a_wr && !fault) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    if (WAIT_CYCLES == 0) begin : g_zw
        assign a_addr         = DataAddr;
        assign a_data         = MemDataIn;
        assign a_op           = MemOp;
        assign a_rd           = MemRead;
        assign a_wr           = MemWrite;
        assign exec           = reset;
        assign mem_ready      = reset;
        assign mem_fault      = reset & fault;
        assign MemReadDataOut = reset ? ldval : '0;
    end else begin : g_ws
        localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
        typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

        state_t      state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
        logic [2:0]  op_q, op_d;
        logic        rd_q, rd_d, wr_q, wr_d, flt_q, flt_d;
        logic        req;

        assign req            = MemRead | MemWrite;
        assign a_addr         = addr_q;
        assign a_data         = data_q;
        assign a_op           = op_q;
        assign a_rd           = rd_q;
        assign a_wr           = wr_q;
        // A store still in flight when reset is sampled never reaches the array.
        assign exec           = reset && (state_q == BUSY) && (cnt_q == '0);
        assign MemReadDataOut = reset ? rdata_q : '0;

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rdata_q <= '0;
                flt_q   <= 1'b0;
                addr_q  <= '0;
                data_q  <= '0;
                op_q    <= '0;
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rdata_q <= rdata_d;
                flt_q   <= flt_d;
                addr_q  <= addr_d;
                data_q  <= data_d;
                op_q    <= op_d;
                rd_q    <= rd_d;
                wr_q    <= wr_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rdata_d   = rdata_q;
            flt_d     = flt_q;
            addr_d    = addr_q;
            data_d    = data_q;
            op_d      = op_q;
            rd_d      = rd_q;
            wr_d      = wr_q;
            mem_ready = 1'b0;
            mem_fault = 1'b0;
            case (state_q)
                IDLE: begin
                    mem_ready = !req;
                    if (req) begin
                        addr_d  = DataAddr;
                        data_d  = MemDataIn;
                        op_d    = MemOp;
                        rd_d    = MemRead;
                        wr_d    = MemWrite;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d = '0;
                        flt_d = fault;
                        if ((rd_q && !wr_q) || fault) rdata_d = ldval;
                        state_d = RESP;
                    end
                end
                RESP: begin
                    mem_ready = 1'b1;
                    mem_fault = flt_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (!reset) begin
                mem_ready = 1'b0;
                mem_fault = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: zero-wait vector table plus wait-state and reset sequences.
module tb_dmem_responder;

    localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                           OP_BU = 3'b100, OP_HU = 3'b101;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] din;
    } req_t;

    typedef struct {
        req_t        rq;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_f;
        string       nm;
    } vec_t;

    typedef struct {
        logic        chk_d;
        logic [31:0] d;
        logic        f;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstz, rst3, rst2;
    req_t rz, r3, r2;
    logic [31:0] dz, d3, d2;
    logic rdyz, rdy3, rdy2, fz, f3, f2;

    dmem_responder #(.WAIT_CYCLES(0)) uz (
        .clk(clk), .reset(rstz), .DataAddr(rz.addr), .MemOp(rz.op), .MemRead(rz.rd),
        .MemWrite(rz.wr), .MemDataIn(rz.din), .MemReadDataOut(dz), .mem_ready(rdyz), .mem_fault(fz));
    dmem_responder #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(rst3), .DataAddr(r3.addr), .MemOp(r3.op), .MemRead(r3.rd),
        .MemWrite(r3.wr), .MemDataIn(r3.din), .MemReadDataOut(d3), .mem_ready(rdy3), .mem_fault(f3));
    dmem_responder #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .reset(rst2), .DataAddr(r2.addr), .MemOp(r2.op), .MemRead(r2.rd),
        .MemWrite(r2.wr), .MemDataIn(r2.din), .MemReadDataOut(d2), .mem_ready(rdy2), .mem_fault(f2));

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic req_t ld(input logic [31:0] a, input logic [2:0] op);
        return '{addr: a, op: op, rd: 1'b1, wr: 1'b0, din: 32'h0};
    endfunction

    function automatic req_t st(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        return '{addr: a, op: op, rd: 1'b0, wr: 1'b1, din: d};
    endfunction

    function automatic void add(input req_t r, input logic c, input logic [31:0] d,
                                input logic f, input string nm);
        vec_t v;
        v.rq = r; v.chk_d = c; v.exp_d = d; v.exp_f = f; v.nm = nm;
        tbl.push_back(v);
    endfunction

    task automatic set_req(input int w, input req_t r);
        if (w == 3) r3 = r;
        else        r2 = r;
    endtask

    function automatic logic rdy_of(input int w);
        return (w == 3) ? rdy3 : rdy2;
    endfunction
    function automatic logic flt_of(input int w);
        return (w == 3) ? f3 : f2;
    endfunction
    function automatic logic [31:0] dat_of(input int w);
        return (w == 3) ? d3 : d2;
    endfunction

    // One wait-mode handshake: hold the request until mem_ready, then drop it.
    task automatic wacc(input int w, input req_t r, input logic c, input logic [31:0] ed,
                        input logic ef, input string nm);
        int   cyc;
        logic got;
        exp_t e;
        @(posedge clk); #1;
        set_req(w, r);
        sb.push_back('{c, ed, ef});
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (rdy_of(w)) got = 1'b1;
            else cyc++;
        end
        e = sb.pop_front();
        if (!got) begin
            n_tot++;
            $display("FAIL %s timeout: mem_ready never rose within 20 cycles", nm);
        end else begin
            chk({nm, " latency"}, 32'(cyc), 32'(w + 1));
            chk({nm, " fault"}, {31'b0, flt_of(w)}, {31'b0, e.f});
            if (e.chk_d) chk({nm, " data"}, dat_of(w), e.d);
        end
        @(posedge clk); #1;
        set_req(w, '0);
    endtask

    initial begin
        exp_t e;

        // Zero-wait vectors.
        add(st(32'h10, OP_W, 32'hDEADBEEF), 1'b0, 32'h0, 1'b0, "sw 10");
        add(ld(32'h10, OP_W),                1'b1, 32'hDEADBEEF, 1'b0, "lw 10 a");
        add(st(32'h10, OP_W, 32'h11223344), 1'b0, 32'h0, 1'b0, "sw 10 b");
        add(st(32'h13, OP_B, 32'h00000080), 1'b0, 32'h0, 1'b0, "sb 13");
        add(ld(32'h13, OP_B),                1'b1, 32'hFFFFFF80, 1'b0, "lb 13");
        add(ld(32'h13, OP_BU),               1'b1, 32'h00000080, 1'b0, "lbu 13");
        add(ld(32'h10, OP_W),                1'b1, 32'h80223344, 1'b0, "lw 10 b");
        add(st(32'h12, OP_H, 32'h0000BEEF), 1'b0, 32'h0, 1'b0, "sh 12");
        add(ld(32'h12, OP_H),                1'b1, 32'hFFFFBEEF, 1'b0, "lh 12");
        add(ld(32'h12, OP_HU),               1'b1, 32'h0000BEEF, 1'b0, "lhu 12");
        add(ld(32'h10, OP_H),                1'b1, 32'h00003344, 1'b0, "lh 10");
        add(ld(32'h11, OP_B),                1'b1, 32'h00000033, 1'b0, "lb 11");
        add(st(32'h10, OP_B, 32'h000000F0), 1'b0, 32'h0, 1'b0, "sb 10");
        add(ld(32'h10, OP_B),                1'b1, 32'hFFFFFFF0, 1'b0, "lb 10");
        add(ld(32'h10, OP_W),                1'b1, 32'hBEEF33F0, 1'b0, "lw 10 c");
        add(st(32'hFFC, OP_W, 32'hCAFEF00D), 1'b0, 32'h0, 1'b0, "sw last");
        add(ld(32'hFFC, OP_W),               1'b1, 32'hCAFEF00D, 1'b0, "lw last");
        add(st(32'h0, OP_W, 32'h01020304),  1'b0, 32'h0, 1'b0, "sw 0");
        add(st(32'h1, OP_B, 32'hFFFFFF7F),  1'b0, 32'h0, 1'b0, "sb 1 hi junk");
        add(ld(32'h1, OP_BU),                1'b1, 32'h0000007F, 1'b0, "lbu 1");
        add(ld(32'h2, OP_H),                 1'b1, 32'h00000102, 1'b0, "lh 2");
        add('{addr: 32'h10, op: OP_W, rd: 1'b0, wr: 1'b0, din: 32'h0},
            1'b1, 32'hBEEF33F0, 1'b0, "idle read");
`ifdef DMEM_FAULT_CHECK_EN
        add(ld(32'h02, OP_W),                1'b1, 32'h0, 1'b1, "lw misaligned");
        add(ld(32'h1000, OP_W),              1'b1, 32'h0, 1'b1, "lw oob");
        add(st(32'h1001, OP_H, 32'hFFFF),   1'b1, 32'h0, 1'b1, "sh 1001");
        add(ld(32'h0, OP_W),                 1'b1, 32'h01027F04, 1'b0, "lw 0 kept");
        add('{addr: 32'h10, op: OP_W, rd: 1'b1, wr: 1'b1, din: 32'h0},
            1'b1, 32'h0, 1'b1, "rd+wr");
        add(ld(32'h10, OP_W),                1'b1, 32'hBEEF33F0, 1'b0, "lw after rd+wr");
        add(ld(32'h10, 3'b011),              1'b1, 32'h0, 1'b1, "op 011");
        add(ld(32'h10, 3'b110),              1'b1, 32'h0, 1'b1, "op 110");
        add(st(32'h10, OP_BU, 32'h0),       1'b1, 32'h0, 1'b1, "store op bu");
        add(ld(32'h11, OP_H),                1'b1, 32'h0, 1'b1, "lh odd");
        add(ld(32'h10, OP_W),                1'b1, 32'hBEEF33F0, 1'b0, "lw 10 kept");
`else
        add(ld(32'h1002, OP_W),              1'b1, 32'h01027F04, 1'b0, "lw wrap");
        add(ld(32'h11, OP_H),                1'b1, 32'h000033F0, 1'b0, "lh odd ign");
        add(ld(32'h10, 3'b011),              1'b1, 32'hBEEF33F0, 1'b0, "op 011 as w");
        add(ld(32'h13, OP_W),                1'b1, 32'hBEEF33F0, 1'b0, "lw low ign");
        add('{addr: 32'h10, op: OP_B, rd: 1'b1, wr: 1'b1, din: 32'h55},
            1'b1, 32'hFFFFFFF0, 1'b0, "rd+wr store");
        add(ld(32'h10, OP_W),                1'b1, 32'hBEEF3355, 1'b0, "lw after rd+wr");
`endif

        rstz = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
        rz = '0; r3 = '0; r2 = '0;
        rz.addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst z rdy", {31'b0, rdyz}, 32'h0);
        chk("rst z flt", {31'b0, fz}, 32'h0);
        chk("rst z dat", dz, 32'h0);
        chk("rst 3 rdy", {31'b0, rdy3}, 32'h0);
        chk("rst 3 flt", {31'b0, f3}, 32'h0);
        chk("rst 3 dat", d3, 32'h0);
        chk("rst 2 rdy", {31'b0, rdy2}, 32'h0);
        chk("rst 2 dat", d2, 32'h0);
        @(posedge clk); #1;
        rstz = 1'b1; rst3 = 1'b1; rst2 = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rz = tbl[i].rq;
            sb.push_back('{tbl[i].chk_d, tbl[i].exp_d, tbl[i].exp_f});
            @(negedge clk);
            e = sb.pop_front();
            chk({tbl[i].nm, " rdy"}, {31'b0, rdyz}, 32'h1);
            chk({tbl[i].nm, " flt"}, {31'b0, fz}, {31'b0, e.f});
            if (e.chk_d) chk({tbl[i].nm, " dat"}, dz, e.d);
        end
        @(posedge clk); #1;
        rz = '0;

        // Wait mode, 3 cycles: cycle-by-cycle mem_ready around one load.
        wacc(3, st(32'h10, OP_W, 32'h5A5A0FF0), 1'b0, 32'h0, 1'b0, "w3 sw");
        @(posedge clk); #1;
        r3 = ld(32'h10, OP_W);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("w3 rdy c%0d", c), {31'b0, rdy3}, {31'b0, (c >= 4)});
            if (c == 4) begin
                chk("w3 lw data", d3, 32'h5A5A0FF0);
                chk("w3 lw flt", {31'b0, f3}, 32'h0);
            end
            if (c == 6) chk("w3 data hold", d3, 32'h5A5A0FF0);
            @(posedge clk); #1;
            if (c == 4) r3 = '0;
        end
        wacc(3, st(32'h12, OP_H, 32'h0000C3C3), 1'b0, 32'h0, 1'b0, "w3 sh");
        wacc(3, ld(32'h12, OP_HU), 1'b1, 32'h0000C3C3, 1'b0, "w3 lhu");
`ifdef DMEM_FAULT_CHECK_EN
        wacc(3, ld(32'h02, OP_W), 1'b1, 32'h0, 1'b1, "w3 lw misaligned");
        @(negedge clk);
        chk("w3 flt clears", {31'b0, f3}, 32'h0);
        chk("w3 idle rdy", {31'b0, rdy3}, 32'h1);
`else
        wacc(3, ld(32'h1012, OP_W), 1'b1, 32'hC3C30FF0, 1'b0, "w3 lw wrap");
`endif

        // Wait mode, 2 cycles: reset during BUSY aborts the pending store.
        wacc(2, st(32'h20, OP_W, 32'h11111111), 1'b0, 32'h0, 1'b0, "w2 sw old");
        @(posedge clk); #1;
        r2 = st(32'h20, OP_W, 32'hA5A5A5A5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(negedge clk);
        chk("w2 rst rdy", {31'b0, rdy2}, 32'h0);
        chk("w2 rst flt", {31'b0, f2}, 32'h0);
        chk("w2 rst dat", d2, 32'h0);
        @(posedge clk); #1;
        r2 = '0;
        @(negedge clk);
        chk("w2 rst rdy 2", {31'b0, rdy2}, 32'h0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        chk("w2 post rst rdy", {31'b0, rdy2}, 32'h1);
        wacc(2, ld(32'h20, OP_W), 1'b1, 32'h11111111, 1'b0, "w2 lw after abort");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's data port.
- Accepts the core's MEM-stage requests (DataAddr, MemOp, MemRead, MemWrite, MemDataIn) and returns MemReadDataOut.
- Implements a word-organised array with byte/half/word access, sign/zero extension, and an optional wait-state FSM.
- Exposes mem_ready and mem_fault for the future stall/trap path.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles per access. 0 selects zero-wait mode.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- DataAddr  in  32  byte address.
- MemOp  in  3  access type, RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- MemDataIn  in  32  store data; right-aligned for B/H.
- MemReadDataOut  out  32  extended load data.
- mem_ready  out  1  access complete / responder idle.
- mem_fault  out  1  current response is a faulted access.

Behaviour:
- **Request and index.** req = MemRead | MemWrite. idx = (DataAddr - BASE_ADDR) >> 2; lane = DataAddr[1:0].
- **Stores.** Write with byte enables; no other byte of the word changes.
  - SB: byte lane = lane.
  - SH: lanes {lane[1],0} and {lane[1],1}.
  - SW: all four lanes.
- **Loads.** Select byte/half by lane, then extend:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: full word.
- **Fault conditions** (compiled per Optional Feature):
  - MemRead and MemWrite both high.
  - MemOp in {011, 110, 111}.
  - Store with MemOp 100/101.
  - H/HU with DataAddr[0]=1.
  - W with DataAddr[1:0]!=0.
  - idx >= DEPTH.
- **Faulted access.** No array write; MemReadDataOut=0; mem_fault=1 exactly while that access's response is presented.
- **WAIT_CYCLES=0 (zero-wait mode).**
  - Reads are asynchronous: MemReadDataOut is valid combinationally in the same cycle as the request.
  - Stores commit at the rising edge ending the request cycle.
  - mem_ready=1 whenever out of reset.
  - mem_fault is combinational from the current request.
  - The FSM stays in IDLE.
- **WAIT_CYCLES>0, FSM IDLE -> BUSY -> RESP.**
  - IDLE: mem_ready=1, mem_fault=0. On req, capture addr/op/data/read-write, load cnt=WAIT_CYCLES-1, go to BUSY. mem_ready drops combinationally in the accept cycle.
  - BUSY: mem_ready=0; the requester holds inputs, but captured copies are used. cnt decrements. At cnt==0 the access executes: store commits at that edge, load data and fault flag are registered. Then go to RESP.
  - RESP: mem_ready=1; MemReadDataOut = registered data; mem_fault = registered flag. Next state is always IDLE. A req still high in the following IDLE cycle is a new access.
  - Latency: request in cycle 0 -> mem_ready high in cycle WAIT_CYCLES+1.
- **MemReadDataOut outside valid responses.**
  - Zero-wait mode: when no load is active, MemReadDataOut is the combinational read of the current address.
  - Wait mode: MemReadDataOut holds its last registered value.
- **Reset** (reset==0 at a rising edge):
  - FSM -> IDLE, cnt=0, registered data=0, registered fault=0.
  - A pending store in BUSY is aborted and never commits.
  - While reset is low: mem_ready=0, mem_fault=0, MemReadDataOut=0.
  - Array contents are not cleared.
- **Simultaneous events.** A store and a load to the same word cannot coexist: there is one port and both requests together are a fault. A load directly following a store to the same word sees the new data.

Optional Feature:
- Macro: DMEM_FAULT_CHECK_EN.
- **Defined:** all fault conditions above are checked; mem_fault behaves as specified.
- **Undefined:**
  - No checking; mem_fault is tied 0.
  - H ignores DataAddr[0]; W ignores DataAddr[1:0].
  - idx wraps modulo DEPTH.
  - Both MemRead and MemWrite high is treated as a store.
  - Reserved MemOp reads as W and writes as SW.

Test Plan:
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> 0xDEADBEEF same cycle, mem_ready=1 throughout.
- SB 0x80 @0x13 over 0x11223344, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW -> 0x80223344.
- WAIT_CYCLES=3: LW at cycle 0 -> mem_ready low cycles 0-3, high cycle 4 with data; idle cycle 5 -> mem_ready=1, no re-access.
- DMEM_FAULT_CHECK_EN, WAIT_CYCLES=0: LW @0x02 -> mem_fault=1, data 0. SH @0x1001 -> word unchanged. LW @DEPTH*4 -> fault.
- WAIT_CYCLES=2: SW 0xA5A5A5A5 @0x20, reset low in the BUSY cycle -> after release, LW @0x20 returns the old value.
- Fault checking off: LW @0x1002 with DEPTH=1024 -> returns word 0 (address wraps, low bits ignored), mem_fault=0.
